// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : ALU operation codes shared by the ALU_Control decoder, the
//                shared-ALU arbiter and the ALU core.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_AND = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
   localparam logic [OP_W-1:0] OP_SLT = 4'b1110;
   localparam logic [OP_W-1:0] OP_SLL = 4'b1111;

   // True for every operation code the ALU implements
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational ALU. Illegal codes give result 0 and
//                raise err.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);

   // Decode the operation and compute the result; only the low shift bits of b count for SLL
   always_comb begin
      result = '0;
      err    = !op_legal(op);
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL:  result = a << b[SHW-1:0];
         default: result = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one ALU between the execute stage (port 0) and the
//                branch/address unit (port 1). Valid/ready requests, one
//                issue per cycle, registered per-port responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int PRIO_MODE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OP_W-1:0]  req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OP_W-1:0]  req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_zero,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_zero,
   output logic             rsp1_err
);

   logic             last_grant;   // 1 when port 1 was granted most recently
   logic             elig0, elig1;
   logic             grant0, grant1;
   logic [OP_W-1:0]  alu_op;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic             alu_err;
   logic             alu_zero;

   // A port may issue when its response slot is empty or being drained this cycle
   assign elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
   assign elig1 = req1_valid && (!rsp1_valid || rsp1_ready);

   // One-hot grant; ties go to port 0 in fixed mode, else to the port not served last
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset) begin
         if (elig0 && elig1) begin
            if ((PRIO_MODE == 1) || last_grant)
               grant0 = 1'b1;
            else
               grant1 = 1'b1;
         end else begin
            grant0 = elig0;
            grant1 = elig1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Round-robin pointer; reset value makes port 0 the first preference
   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= 1'b1;
      else if (grant0 || grant1)
         last_grant <= grant1;
   end

   // Steer the granted operands into the single ALU
   assign alu_op = grant1 ? req1_op : req0_op;
   assign alu_a  = grant1 ? req1_a  : req0_a;
   assign alu_b  = grant1 ? req1_b  : req0_b;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu_core (
      .op     (alu_op),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_result),
      .err    (alu_err)
   );

   assign alu_zero = (alu_result == '0);

   // Port 0 response register: load on grant, clear valid on a drain without refill
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp0_zero   <= 1'b0;
         rsp0_err    <= 1'b0;
      end else if (grant0) begin
         rsp0_valid  <= 1'b1;
         rsp0_result <= alu_result;
         rsp0_zero   <= alu_zero;
         rsp0_err    <= alu_err;
      end else if (rsp0_ready) begin
         rsp0_valid  <= 1'b0;
      end
   end

   // Port 1 response register: load on grant, clear valid on a drain without refill
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
         rsp1_zero   <= 1'b0;
         rsp1_err    <= 1'b0;
      end else if (grant1) begin
         rsp1_valid  <= 1'b1;
         rsp1_result <= alu_result;
         rsp1_zero   <= alu_zero;
         rsp1_err    <= alu_err;
      end else if (rsp1_ready) begin
         rsp1_valid  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench for alu_share_arbiter, round-robin and
//                fixed-priority builds, with a per-port result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
   import alu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // Round-robin instance signals
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
   logic         rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
   logic [W-1:0] rsp0_result, rsp1_result;

   // Fixed-priority instance signals
   logic         p_req0_valid, p_req0_ready, p_req1_valid, p_req1_ready;
   logic [3:0]   p_req0_op, p_req1_op;
   logic [W-1:0] p_req0_a, p_req0_b, p_req1_a, p_req1_b;
   logic         p_rsp0_valid, p_rsp0_ready, p_rsp0_zero, p_rsp0_err;
   logic         p_rsp1_valid, p_rsp1_ready, p_rsp1_zero, p_rsp1_err;
   logic [W-1:0] p_rsp0_result, p_rsp1_result;

   alu_share_arbiter #(.WIDTH(W), .PRIO_MODE(0)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err)
   );

   alu_share_arbiter #(.WIDTH(W), .PRIO_MODE(1)) u_dut_prio (
      .clk(clk), .reset(reset),
      .req0_valid(p_req0_valid), .req0_ready(p_req0_ready), .req0_op(p_req0_op),
      .req0_a(p_req0_a), .req0_b(p_req0_b),
      .req1_valid(p_req1_valid), .req1_ready(p_req1_ready), .req1_op(p_req1_op),
      .req1_a(p_req1_a), .req1_b(p_req1_b),
      .rsp0_valid(p_rsp0_valid), .rsp0_ready(p_rsp0_ready), .rsp0_result(p_rsp0_result),
      .rsp0_zero(p_rsp0_zero), .rsp0_err(p_rsp0_err),
      .rsp1_valid(p_rsp1_valid), .rsp1_ready(p_rsp1_ready), .rsp1_result(p_rsp1_result),
      .rsp1_zero(p_rsp1_zero), .rsp1_err(p_rsp1_err)
   );

   int checks = 0;
   int passed = 0;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs === exp)
         passed++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   typedef struct packed {
      logic [W-1:0] result;
      logic         zero;
      logic         err;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   // Reference ALU
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.err = 1'b0;
      case (op)
         4'b0000: e.result = a & b;
         4'b0001: e.result = a | b;
         4'b0010: e.result = a + b;
         4'b0110: e.result = a - b;
         4'b1110: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1111: e.result = a << (b % 32);
         default: begin e.result = '0; e.err = 1'b1; end
      endcase
      e.zero = (e.result == 0);
      return e;
   endfunction

   // Scoreboard: compare drained responses, then record new handshakes
   always @(negedge clk) begin
      if (reset) begin
         q0.delete();
         q1.delete();
      end else begin
         if (rsp0_valid && rsp0_ready) begin
            if (q0.size() == 0) check_value("rsp0_unexpected", 1, 0);
            else begin
               e0 = q0.pop_front();
               check_value("rsp0_result", rsp0_result, e0.result);
               check_value("rsp0_zero", rsp0_zero, e0.zero);
               check_value("rsp0_err", rsp0_err, e0.err);
            end
         end
         if (rsp1_valid && rsp1_ready) begin
            if (q1.size() == 0) check_value("rsp1_unexpected", 1, 0);
            else begin
               e1 = q1.pop_front();
               check_value("rsp1_result", rsp1_result, e1.result);
               check_value("rsp1_zero", rsp1_zero, e1.zero);
               check_value("rsp1_err", rsp1_err, e1.err);
            end
         end
         if (req0_valid && req0_ready) q0.push_back(model(req0_op, req0_a, req0_b));
         if (req1_valid && req1_ready) q1.push_back(model(req1_op, req1_a, req1_b));
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
   endtask

   task automatic drive1(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
   endtask

   task automatic pdrive(input logic v0, input logic [W-1:0] a0, input logic v1);
      p_req0_valid = v0; p_req0_op = OP_ADD; p_req0_a = a0; p_req0_b = 32'd10;
      p_req1_valid = v1; p_req1_op = OP_OR;  p_req1_a = 32'hF0; p_req1_b = 32'h0F;
   endtask

   logic [3:0]   t2_op0 [4] = '{OP_ADD, OP_OR, OP_AND, OP_SLL};
   logic [W-1:0] t2_a0  [4] = '{32'd1, 32'h0F00, 32'hFF00, 32'd3};
   logic [W-1:0] t2_b0  [4] = '{32'd2, 32'h00F0, 32'h0FF0, 32'd4};
   logic [3:0]   t2_op1 [4] = '{OP_SUB, OP_ADD, OP_SUB, OP_SLT};
   logic [W-1:0] t2_a1  [4] = '{32'd3, 32'hFFFFFFFF, 32'd10, 32'd5};
   logic [W-1:0] t2_b1  [4] = '{32'd3, 32'd1, 32'd4, 32'd2};

   logic [3:0]   t4_op  [7] = '{OP_SUB, OP_SLT, OP_SLT, OP_SLL, 4'b0101, OP_AND, OP_OR};
   logic [W-1:0] t4_a   [7] = '{32'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd7, 32'hF0F0, 32'hF000};
   logic [W-1:0] t4_b   [7] = '{32'd1, 32'd1, 32'hFFFFFFFF, 32'd35, 32'd9, 32'h0FF0, 32'h000F};
   logic [W-1:0] t4_res [7] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd8, 32'd0, 32'h00F0, 32'hF00F};
   logic         t4_err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      int i0, i1;
      reset = 1'b1;
      drive0(1'b1, OP_ADD, 32'd1, 32'd1);
      drive1(1'b1, OP_ADD, 32'd2, 32'd2);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      pdrive(1'b1, 32'd0, 1'b1);
      p_rsp0_ready = 1'b1; p_rsp1_ready = 1'b1;

      // 1. reset state, then a single ADD
      repeat (2) begin
         @(negedge clk);
         check_value("rst_req0_ready", req0_ready, 0);
         check_value("rst_req1_ready", req1_ready, 0);
         check_value("rst_rsp0_valid", rsp0_valid, 0);
         check_value("rst_rsp1_valid", rsp1_valid, 0);
         check_value("rst_rsp0_flags", {rsp0_result, rsp0_zero, rsp0_err}, 0);
         check_value("rst_p_ready", {p_req0_ready, p_req1_ready}, 0);
      end
      next_cycle();
      reset = 1'b0;
      pdrive(1'b0, 32'd0, 1'b0);
      drive0(1'b1, OP_ADD, 32'd5, 32'd7);
      drive1(1'b0, OP_AND, 32'd0, 32'd0);
      @(negedge clk);
      check_value("t1_req0_ready", req0_ready, 1);
      next_cycle();
      drive0(1'b0, OP_AND, 32'd0, 32'd0);
      @(negedge clk);
      check_value("t1_rsp0_valid", rsp0_valid, 1);
      check_value("t1_rsp0_result", rsp0_result, 12);
      check_value("t1_rsp0_zero", rsp0_zero, 0);

      // 2. both ports contend every cycle: grants alternate, port 1 first here
      i0 = 0; i1 = 0;
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         drive0(1'b1, t2_op0[i0], t2_a0[i0], t2_b0[i0]);
         drive1(1'b1, t2_op1[i1], t2_a1[i1], t2_b1[i1]);
         @(negedge clk);
         check_value("t2_grant", {req0_ready, req1_ready}, (c % 2 == 0) ? 2'b01 : 2'b10);
         if (req0_ready) i0++;
         if (req1_ready) i1++;
      end

      // 3. port 1 response stalled: port 1 blocked, port 0 streams, then drain+refill
      next_cycle();
      rsp1_ready = 1'b0;
      drive0(1'b0, OP_AND, 32'd0, 32'd0);
      drive1(1'b1, OP_ADD, 32'd100, 32'd23);
      @(negedge clk);
      check_value("t3_fill_ready1", req1_ready, 1);
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         drive0(1'b1, OP_ADD, k, 32'd1000);
         drive1(1'b1, OP_SUB, 32'd50, 32'd8);
         @(negedge clk);
         check_value("t3_ready1_blocked", req1_ready, 0);
         check_value("t3_ready0_stream", req0_ready, 1);
         check_value("t3_hold_valid", rsp1_valid, 1);
         check_value("t3_hold_result", rsp1_result, 123);
      end
      next_cycle();
      rsp1_ready = 1'b1;
      drive0(1'b1, OP_ADD, 32'd9, 32'd1000);
      @(negedge clk);
      check_value("t3_refill_ready1", req1_ready, 1);
      next_cycle();
      drive0(1'b0, OP_AND, 32'd0, 32'd0);
      drive1(1'b0, OP_AND, 32'd0, 32'd0);
      @(negedge clk);
      check_value("t3_refill_result", rsp1_result, 42);

      // 4. operation coverage on port 0
      for (int k = 0; k < 7; k++) begin
         next_cycle();
         drive0(1'b1, t4_op[k], t4_a[k], t4_b[k]);
         @(negedge clk);
         check_value("t4_ready0", req0_ready, 1);
         next_cycle();
         drive0(1'b0, OP_AND, 32'd0, 32'd0);
         @(negedge clk);
         check_value("t4_result", rsp0_result, t4_res[k]);
         check_value("t4_err", rsp0_err, t4_err[k]);
         check_value("t4_zero", rsp0_zero, (t4_res[k] == 0));
      end

      // 5. fixed priority: port 0 wins while valid, port 1 waits with payload held
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         pdrive(1'b1, k, 1'b1);
         @(negedge clk);
         check_value("t5_p_grant", {p_req0_ready, p_req1_ready}, 2'b10);
      end
      next_cycle();
      pdrive(1'b0, 32'd0, 1'b1);
      @(negedge clk);
      check_value("t5_p_ready1", p_req1_ready, 1);
      next_cycle();
      pdrive(1'b0, 32'd0, 1'b0);
      @(negedge clk);
      check_value("t5_p_rsp1", {p_rsp1_valid, p_rsp1_result, p_rsp1_err}, {1'b1, 32'hFF, 1'b0});
      check_value("t5_p_rsp0_cleared", p_rsp0_valid, 0);
      check_value("t5_p_rsp0_kept", p_rsp0_result, 13);

      // 6. reset during a pending response and a presented request
      next_cycle();
      rsp0_ready = 1'b0;
      drive0(1'b1, OP_ADD, 32'd9, 32'd9);
      @(negedge clk);
      check_value("t6_ready0", req0_ready, 1);
      next_cycle();
      reset = 1'b1;
      drive0(1'b1, OP_ADD, 32'd1, 32'd1);
      @(negedge clk);
      check_value("t6_ready0_in_reset", req0_ready, 0);
      next_cycle();
      reset = 1'b0;
      drive0(1'b0, OP_AND, 32'd0, 32'd0);
      rsp0_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check_value("t6_no_rsp0", rsp0_valid, 0);
         next_cycle();
      end

      repeat (2) next_cycle();
      check_value("sb_q0_empty", q0.size(), 0);
      check_value("sb_q1_empty", q1.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
